// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared constants for the pipelined integer square-root stages
package sqrt_pkg;

  localparam int W   = 8;
  localparam int R_W = W / 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_ITER = 2'b01;
  localparam state_t ST_DONE = 2'b10;

  // Stage-2 register reset values: k = 3.
  localparam int SEED_SQUARE = 9;
  localparam int SEED_DELTA  = 7;

endpackage

// File: rtl/dffa.sv
// rtl/dffa.sv - enabled register cell with asynchronous active-low reset
module dffa #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one odd-number-sum step: compare, add delta, bump delta by two
module sqrt_step #(
  parameter int W   = 8,
  parameter int R_W = 4
) (
  input  logic [W:0]     square,
  input  logic [R_W+1:0] delta,
  input  logic [W-1:0]   radicand,
  output logic           le,
  output logic [W:0]     square_next,
  output logic [R_W+1:0] delta_next,
  output logic [R_W-1:0] root
);

  always_comb begin
    le          = square <= {1'b0, radicand};
    square_next = square + {{(W-R_W-1){1'b0}}, delta};
    delta_next  = delta + (R_W+2)'(2);
    // delta = 2k+1, so (delta>>1)-1 = k-1; bit 0 of delta is always set
    root        = delta[R_W:1] - R_W'(1);
  end

endmodule

// File: rtl/sqrt_iter_s3.sv
// rtl/sqrt_iter_s3.sv - stage 3 of the integer square root: iterate from stage-2 seeds to the final root
module sqrt_iter_s3
  import sqrt_pkg::*;
#(
  parameter int W       = 8,
  parameter int SQ_IN_W = 5,
  parameter int D_IN_W  = 4,
  parameter int R_W     = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_radicand,
  input  logic [SQ_IN_W-1:0] in_square,
  input  logic [D_IN_W-1:0]  in_delta,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [R_W-1:0]     out_root,
  output logic               busy
);

  localparam int SQ_W = W + 1;
  localparam int D_W  = R_W + 2;

  state_t         state_q, state_d;
  logic [SQ_W-1:0] square_q, square_d;
  logic [D_W-1:0]  delta_q, delta_d;
  logic [W-1:0]    radicand_q, radicand_d;
  logic [R_W-1:0]  root_q, root_d;

  logic [SQ_W-1:0] sq_seed;
  logic [D_W-1:0]  d_seed;
  logic [SQ_W-1:0] step_sq_in, step_sq_next;
  logic [D_W-1:0]  step_d_in, step_d_next;
  logic [W-1:0]    step_rad_in;
  logic            step_le;
  logic [R_W-1:0]  step_root;

  assign sq_seed = {{(SQ_W-SQ_IN_W){1'b0}}, in_square};
  assign d_seed  = {{(D_W-D_IN_W){1'b0}}, in_delta};

  // In IDLE the single step unit evaluates the incoming seeds for the direct path.
  assign step_sq_in  = (state_q == ST_IDLE) ? sq_seed     : square_q;
  assign step_d_in   = (state_q == ST_IDLE) ? d_seed      : delta_q;
  assign step_rad_in = (state_q == ST_IDLE) ? in_radicand : radicand_q;

  sqrt_step #(.W(W), .R_W(R_W)) u_step (
    .square      (step_sq_in),
    .delta       (step_d_in),
    .radicand    (step_rad_in),
    .le          (step_le),
    .square_next (step_sq_next),
    .delta_next  (step_d_next),
    .root        (step_root)
  );

  dffa #(.WIDTH(2))    u_state    (.clock(clock), .reset(reset), .en(enable), .d(state_d),    .q(state_q));
  dffa #(.WIDTH(SQ_W)) u_square   (.clock(clock), .reset(reset), .en(enable), .d(square_d),   .q(square_q));
  dffa #(.WIDTH(D_W))  u_delta    (.clock(clock), .reset(reset), .en(enable), .d(delta_d),    .q(delta_q));
  dffa #(.WIDTH(W))    u_radicand (.clock(clock), .reset(reset), .en(enable), .d(radicand_d), .q(radicand_q));
  dffa #(.WIDTH(R_W))  u_root     (.clock(clock), .reset(reset), .en(enable), .d(root_d),     .q(root_q));

  always_comb begin
    state_d    = state_q;
    square_d   = square_q;
    delta_d    = delta_q;
    radicand_d = radicand_q;
    root_d     = root_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          radicand_d = in_radicand;
          square_d   = sq_seed;
          delta_d    = d_seed;
          if (step_le) begin
            state_d = ST_ITER;
          end else begin
            root_d  = step_root;
            state_d = ST_DONE;
          end
        end
      end
      ST_ITER: begin
        if (step_le) begin
          square_d = step_sq_next;
          delta_d  = step_d_next;
        end else begin
          root_d  = step_root;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // in_ready is gated by reset so it stays low while reset is held.
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && reset;
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_ITER);
    out_root  = root_q;
  end

endmodule

// File: tb/tb_sqrt_iter_s3.sv
// tb/tb_sqrt_iter_s3.sv - directed self-checking bench for sqrt_iter_s3
module tb_sqrt_iter_s3;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_radicand;
  logic [4:0] in_square;
  logic [3:0] in_delta;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_root;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int e;

  sqrt_iter_s3 dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_radicand (in_radicand),
    .in_square   (in_square),
    .in_delta    (in_delta),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_root    (out_root),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic submit(input int rad, input int sq, input int dl);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    check("submit_in_ready", 32'(in_ready), 1);
    in_radicand = 8'(rad);
    in_square   = 5'(sq);
    in_delta    = 4'(dl);
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!out_valid && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    reset       = 1'b0;
    enable      = 1'b1;
    in_valid    = 1'b0;
    in_radicand = '0;
    in_square   = '0;
    in_delta    = '0;
    out_ready   = 1'b1;

    // reset state
    repeat (2) tick();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_root", 32'(out_root), 0);
    check("rst_square", 32'(dut.square_q), 0);
    check("rst_delta", 32'(dut.delta_q), 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 1);

    // radicand 10: one addition
    submit(10, 9, 7);
    check("r10_busy", 32'(busy), 1);
    check("r10_square_after_accept", 32'(dut.square_q), 9);
    wait_done(e);
    check("r10_latency", 32'(e), 2);
    check("r10_root", 32'(out_root), 3);
    check("r10_square", 32'(dut.square_q), 16);
    check("r10_delta", 32'(dut.delta_q), 9);
    tick();
    check("r10_valid_drop", 32'(out_valid), 0);
    check("r10_in_ready_back", 32'(in_ready), 1);

    // radicand 255: worst case
    submit(255, 9, 7);
    wait_done(e);
    check("r255_latency", 32'(e), 14);
    check("r255_root", 32'(out_root), 15);
    check("r255_square", 32'(dut.square_q), 256);
    check("r255_delta", 32'(dut.delta_q), 33);
    tick();

    // radicand 4: direct path
    submit(4, 9, 7);
    check("r4_valid", 32'(out_valid), 1);
    check("r4_root", 32'(out_root), 2);
    check("r4_busy", 32'(busy), 0);
    tick();
    check("r4_valid_drop", 32'(out_valid), 0);

    // radicand 81 with backpressure
    out_ready = 1'b0;
    submit(81, 9, 7);
    wait_done(e);
    check("r81_latency", 32'(e), 8);
    check("r81_root", 32'(out_root), 9);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("r81_hold_root", 32'(out_root), 9);
      check("r81_hold_valid", 32'(out_valid), 1);
      check("r81_hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    check("r81_release_valid", 32'(out_valid), 0);
    check("r81_release_in_ready", 32'(in_ready), 1);

    // radicand 200 aborted by reset, then radicand 49
    submit(200, 9, 7);
    tick();
    tick();
    check("r200_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_state", 32'(dut.state_q), 0);
    check("abort_in_ready", 32'(in_ready), 0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    submit(49, 9, 7);
    wait_done(e);
    check("r49_latency", 32'(e), 6);
    check("r49_root", 32'(out_root), 7);
    tick();

    // radicand 100 with enable low for 3 cycles mid-ITER
    submit(100, 9, 7);
    tick();
    tick();
    check("r100_square_pre", 32'(dut.square_q), 25);
    check("r100_delta_pre", 32'(dut.delta_q), 11);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r100_frozen_square", 32'(dut.square_q), 25);
      check("r100_frozen_delta", 32'(dut.delta_q), 11);
      check("r100_frozen_busy", 32'(busy), 1);
    end
    enable = 1'b1;
    wait_done(e);
    check("r100_latency", 32'(e + 5), 12);
    check("r100_root", 32'(out_root), 10);
    tick();
    check("r100_valid_drop", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sqrt_iter_s3.md
Name: sqrt_iter_s3

Overview:
- Third stage of the pipelined integer square-root datapath.
- Consumes the stage-2 pipeline register outputs (partial square, odd increment) together with the radicand. It finishes the odd-number-sum iteration over multiple cycles, one comparison per cycle, using the 8-bit comparator.
- Produces the final root under a valid/ready handshake for the output register stage.
- Seeds default to the stage-2 reset values: square = 9, delta = 7, which is k = 3.

Parameters:
- W, 8, radicand width in bits.
- SQ_IN_W, 5, width of the incoming square seed from the stage-2 register.
- D_IN_W, 4, width of the incoming delta seed.
- R_W, 4, root width (W/2).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. Clears all state immediately.
- enable  input  1  when low, all state and outputs are frozen and handshakes are ignored.
- in_valid  input  1  upstream has a radicand and seeds.
- in_ready  output  1  block can accept; high only in IDLE.
- in_radicand  input  W  value whose root is computed.
- in_square  input  SQ_IN_W  seed square, k*k.
- in_delta  input  D_IN_W  seed increment, 2k+1.
- out_valid  output  1  root available.
- out_ready  input  1  downstream accepts root.
- out_root  output  R_W  floor(sqrt(in_radicand)).
- busy  output  1  high in ITER.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, square_q=0, delta_q=0, radicand_q=0, out_root=0, out_valid=0, busy=0, in_ready=0 while reset is held.
  - in_ready rises in IDLE after release.
- Internal widths:
  - square_q: W+1 bits (9), so the maximum 256 fits.
  - delta_q: R_W+2 bits (6), maximum 33.
  - Seeds are zero-extended on capture.
  - Comparison is unsigned: square_q <= {0,radicand_q}.
- Precondition: the upstream stage guarantees radicand >= (k-1)^2, where k = (in_delta-1)/2. The block does not check it.
- FSM with states IDLE, ITER, DONE.
  - IDLE: in_ready=1. On in_valid & enable, capture the radicand and seeds.
    - If in_square > in_radicand: go to DONE with out_root = (in_delta>>1)-1.
    - Else: go to ITER.
  - ITER: busy=1, in_ready=0. Each enabled edge:
    - If square_q <= radicand_q: square_q += delta_q and delta_q += 2.
    - Else: out_root = (delta_q>>1)-1, go to DONE.
  - DONE: out_valid=1. out_root is held stable until out_valid & out_ready & enable, then go to IDLE. out_valid drops the next cycle.
- The block never accepts a new input in the cycle it releases a result; there is one IDLE cycle minimum between jobs.
- Latency from the accept edge to out_valid high:
  - 0 extra edges on the direct path (out_valid visible right after the accept edge).
  - n+1 edges otherwise, where n = number of additions.
  - Worst case with default seeds: radicand 255 gives n=13, so out_valid after 14 edges following accept.
- enable=0 mid-ITER or in DONE: no state change; out_valid and out_root hold.
- Reset asserted mid-ITER or DONE: immediate abort. The result is discarded and the block returns to IDLE.
- out_ready high while out_valid=0: ignored.
- in_valid high outside IDLE: ignored. Upstream must hold it until in_ready.

Decomposition:
- Shared package sqrt_pkg:
  - State encoding constants ST_IDLE=2'b00, ST_ITER=2'b01, ST_DONE=2'b10.
  - SEED_SQUARE=9 and SEED_DELTA=7, the stage-2 reset values.
  - Width constants W, R_W.
- One natural sub-module: sqrt_step, the combinational compare/add/+2 step. It is reused by the earlier stages.
- State registers are built from the existing dffa cell with enable tied to enable.

Test Plan:
- Radicand 10, square 9, delta 7, out_ready=1: one addition (square 16, delta 9), then out_root=3, out_valid after 2 edges.
- Radicand 255, seeds 9/7: square reaches 256 and delta 33. out_root=15 after 14 edges, with no square overflow.
- Radicand 4, seeds 9/7: direct path, out_root=2 visible right after the accept edge, busy never high.
- Radicand 81, out_ready held low 5 cycles after out_valid: out_root=9 stays stable and in_ready stays 0. Release in the cycle out_ready=1, in_ready=1 on the following cycle.
- Radicand 200, reset pulled low two edges into ITER: out_valid=0, state IDLE immediately. After release, a new job with radicand 49 gives out_root=7.
- Radicand 100, enable low for 3 cycles mid-ITER: square_q and delta_q frozen. Total latency grows by exactly 3 and out_root=10.
